// File: rtl/multicycle_cu_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_RDATA  = 2'b01,
    RES_ALURES = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SA_PC    = 2'b00,
    SA_OLDPC = 2'b01,
    SA_RS1   = 2'b10,
    SA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SB_RS2  = 2'b00,
    SB_IMM  = 2'b01,
    SB_FOUR = 2'b10
  } src_b_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/multicycle_cu_if.sv
// Control unit <-> instruction register / datapath signal bundle.
interface multicycle_cu_if #(
  parameter int ALUC_W = 4
);
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              zero;
  logic              lt;
  logic              ltu;
  logic              mem_ready;
  logic              pc_write;
  logic              adr_src;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              reg_write;
  logic [1:0]        result_src;
  logic [1:0]        alu_src_a;
  logic [1:0]        alu_src_b;
  logic [ALUC_W-1:0] alu_control;
  logic [2:0]        imm_src;
  logic              trap;
  logic [3:0]        state_o;

  modport master (
    input  op, funct3, funct7_5, zero, lt, ltu, mem_ready,
    output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src, trap, state_o
  );

  modport slave (
    output op, funct3, funct7_5, zero, lt, ltu, mem_ready,
    input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src, trap, state_o
  );
endinterface

// File: rtl/multicycle_cu_alu_op_deco.sv
// ALU operation decode for R-type and I-type arithmetic instructions.
module alu_op_deco
  import cu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  input  logic       is_rtype,
  output alu_op_t    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      // addi has no sub form; instr[30] is immediate data there
      3'b000:  alu_op = (funct7_5 && (is_rtype || op5)) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: Moore FSM driving datapath muxes and enables.
//   state     | meaning
//   FETCH     | read instr at PC, PC <= PC+4 on mem_ready
//   DECODE    | ALUOut <= oldPC+imm (branch/jal target), dispatch on op
//   MEMADR    | ALUOut <= rs1+imm
//   MEMREAD   | load data read, wait for mem_ready
//   MEMWB     | rd <= ReadData
//   MEMWRITE  | store, wait for mem_ready
//   EXECR/I   | ALU op on rs1 with rs2/imm
//   ALUWB     | rd <= ALUOut
//   BRANCH    | compare rs1/rs2, PC <= ALUOut if taken
//   JAL       | PC <= ALUOut, ALU computes link
//   JALR      | PC <= rs1+imm
//   JALR_LINK | ALU computes link oldPC+4
//   LUI       | 0+immU
//   TRAP      | illegal instruction, sticky until reset
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int ALUC_W        = 4,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit BRANCH_EXT    = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_cu_if.master bus
);

  state_t      state_q, state_d;
  alu_op_t     deco_op, alu_op;
  imm_src_t    imm_src;
  result_src_t res_src;
  src_a_t      src_a;
  src_b_t      src_b;
  logic        rdy, br_legal, br_cond;
  logic        pc_w, ir_w, reg_w, mem_rd, mem_wr, adr_s, trap_s;

  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  alu_op_deco u_alu_op_deco (
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .op5      (bus.op[5]),
    .is_rtype (state_q == S_EXECR),
    .alu_op   (deco_op)
  );

  always_comb begin
    br_cond  = 1'b0;
    br_legal = BRANCH_EXT;
    case (bus.funct3)
      F3_BEQ:  begin br_legal = 1'b1; br_cond = bus.zero; end
      F3_BNE:  br_cond = ~bus.zero;
      F3_BLT:  br_cond = bus.lt;
      F3_BGE:  br_cond = ~bus.lt;
      F3_BLTU: br_cond = bus.ltu;
      F3_BGEU: br_cond = ~bus.ltu;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    adr_s   = 1'b0;
    trap_s  = 1'b0;
    res_src = RES_ALUOUT;
    src_a   = SA_PC;
    src_b   = SB_RS2;
    alu_op  = ALU_ADD;
    imm_src = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        src_b   = SB_FOUR;
        res_src = RES_ALURES;
        if (rdy) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a   = SA_OLDPC;
        src_b   = SB_IMM;
        imm_src = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a   = SA_RS1;
        src_b   = SB_IMM;
        imm_src = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_s  = 1'b1;
        mem_rd = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = RES_RDATA;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_s  = 1'b1;
        mem_wr = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = SA_RS1;
        alu_op  = deco_op;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SA_RS1;
        src_b   = SB_IMM;
        alu_op  = deco_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a  = SA_RS1;
        alu_op = ALU_SUB;
        if (br_legal) begin
          pc_w    = br_cond;
          state_d = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_JAL: begin
        src_a   = SA_OLDPC;
        src_b   = SB_FOUR;
        pc_w    = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        src_a   = SA_RS1;
        src_b   = SB_IMM;
        pc_w    = 1'b1;
        res_src = RES_ALURES;
        state_d = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        src_a   = SA_OLDPC;
        src_b   = SB_FOUR;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        src_a   = SA_ZERO;
        src_b   = SB_IMM;
        imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      S_TRAP:  trap_s = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // enables are forced low while reset is held so nothing writes mid-reset
  assign bus.pc_write    = pc_w   & rst_n;
  assign bus.ir_write    = ir_w   & rst_n;
  assign bus.reg_write   = reg_w  & rst_n;
  assign bus.mem_read    = mem_rd & rst_n;
  assign bus.mem_write   = mem_wr & rst_n;
  assign bus.adr_src     = adr_s;
  assign bus.trap        = trap_s;
  assign bus.result_src  = res_src;
  assign bus.alu_src_a   = src_a;
  assign bus.alu_src_b   = src_b;
  assign bus.alu_control = ALUC_W'(alu_op);
  assign bus.imm_src     = imm_src;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: per-cycle expectations queued, then checked.
module tb_multicycle_cu;
  import cu_pkg::*;

  localparam logic [6:0] E_NONE   = 7'b0000000;
  localparam logic [6:0] E_FSTALL = 7'b0001000;
  localparam logic [6:0] E_FGO    = 7'b1101000;
  localparam logic [6:0] E_RW     = 7'b0010000;
  localparam logic [6:0] E_MRD    = 7'b0001010;
  localparam logic [6:0] E_MWR    = 7'b0000110;
  localparam logic [6:0] E_PC     = 7'b1000000;
  localparam logic [6:0] E_TRAP   = 7'b0000001;

  typedef struct {
    string      tag;
    logic       rdy;
    logic [3:0] st;
    logic [6:0] en;
    logic [1:0] rsrc;
    logic [1:0] chk;
    logic [3:0] aluc;
    logic [2:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst1_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic mr0 = 1'b0, mr1 = 1'b0;
  int errors = 0, checks = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  multicycle_cu_if #(.ALUC_W(4)) if0 ();
  multicycle_cu_if #(.ALUC_W(4)) if1 ();

  assign if0.op = op;       assign if1.op = op;
  assign if0.funct3 = funct3;   assign if1.funct3 = funct3;
  assign if0.funct7_5 = funct7_5; assign if1.funct7_5 = funct7_5;
  assign if0.zero = zero;   assign if1.zero = zero;
  assign if0.lt = lt;       assign if1.lt = lt;
  assign if0.ltu = ltu;     assign if1.ltu = ltu;
  assign if0.mem_ready = mr0;
  assign if1.mem_ready = mr1;

  multicycle_cu #(.ALUC_W(4), .MEM_HANDSHAKE(1'b1), .BRANCH_EXT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  multicycle_cu #(.ALUC_W(4), .MEM_HANDSHAKE(1'b0), .BRANCH_EXT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(if1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input logic [3:0] st,
                      input logic [6:0] en, input logic [1:0] rsrc,
                      input logic [1:0] chkm = 2'b00, input logic [3:0] aluc = 4'd0,
                      input logic [2:0] imm = 3'd0);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.st = st; e.en = en; e.rsrc = rsrc;
    e.chk = chkm; e.aluc = aluc; e.imm = imm;
    sbq.push_back(e);
  endtask

  task automatic drain(input logic sel);
    exp_t e;
    logic [3:0] st, aluc;
    logic [6:0] en;
    logic [1:0] rsrc;
    logic [2:0] imm;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (sel) mr1 = e.rdy; else mr0 = e.rdy;
      @(negedge clk);
      if (sel) begin
        st = if1.state_o; aluc = if1.alu_control; rsrc = if1.result_src; imm = if1.imm_src;
        en = {if1.pc_write, if1.ir_write, if1.reg_write, if1.mem_read,
              if1.mem_write, if1.adr_src, if1.trap};
      end else begin
        st = if0.state_o; aluc = if0.alu_control; rsrc = if0.result_src; imm = if0.imm_src;
        en = {if0.pc_write, if0.ir_write, if0.reg_write, if0.mem_read,
              if0.mem_write, if0.adr_src, if0.trap};
      end
      chk({e.tag, "_state"}, 16'(st), 16'(e.st));
      chk({e.tag, "_en"}, 16'(en), 16'(e.en));
      chk({e.tag, "_rsrc"}, 16'(rsrc), 16'(e.rsrc));
      if (e.chk[0]) chk({e.tag, "_aluc"}, 16'(aluc), 16'(e.aluc));
      if (e.chk[1]) chk({e.tag, "_imm"}, 16'(imm), 16'(e.imm));
      @(posedge clk);
      #1;
    end
  endtask

  // half-cycle reset pulse between edges; state must return to FETCH at once
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_rst_state"}, 16'(if0.state_o), 16'(S_FETCH));
    chk({tag, "_rst_en"}, 16'({if0.pc_write, if0.ir_write, if0.reg_write,
        if0.mem_read, if0.mem_write, if0.trap}), 16'd0);
    mr0 = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7_5 = f7;
  endtask

  initial begin
    #12;
    chk("reset_state", 16'(if0.state_o), 16'(S_FETCH));
    chk("reset_en", 16'({if0.pc_write, if0.ir_write, if0.reg_write, if0.mem_read,
        if0.mem_write, if0.trap}), 16'd0);
    chk("reset1_mem_read", 16'(if1.mem_read), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_instr(OP_RTYPE, 3'b000, 1'b0);
    push("add_f", 1, S_FETCH, E_FGO, 2'b10, 2'b01, 4'd0);
    push("add_d", 1, S_DECODE, E_NONE, 2'b00, 2'b10, 4'd0, 3'b010);
    push("add_x", 1, S_EXECR, E_NONE, 2'b00, 2'b01, 4'd0);
    push("add_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_RTYPE, 3'b000, 1'b1);
    push("sub_f", 1, S_FETCH, E_FGO, 2'b10);
    push("sub_d", 1, S_DECODE, E_NONE, 2'b00);
    push("sub_x", 1, S_EXECR, E_NONE, 2'b00, 2'b01, 4'd1);
    push("sub_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_ITYPE, 3'b101, 1'b1);
    push("srai_f", 1, S_FETCH, E_FGO, 2'b10);
    push("srai_d", 1, S_DECODE, E_NONE, 2'b00);
    push("srai_x", 1, S_EXECI, E_NONE, 2'b00, 2'b11, 4'd9, 3'b000);
    push("srai_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_ITYPE, 3'b000, 1'b1);
    push("addi_f", 1, S_FETCH, E_FGO, 2'b10);
    push("addi_d", 1, S_DECODE, E_NONE, 2'b00);
    push("addi_x", 1, S_EXECI, E_NONE, 2'b00, 2'b01, 4'd0);
    push("addi_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_LOAD, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) push("lw_fstall", 0, S_FETCH, E_FSTALL, 2'b10);
    push("lw_f", 1, S_FETCH, E_FGO, 2'b10);
    push("lw_d", 1, S_DECODE, E_NONE, 2'b00);
    push("lw_adr", 1, S_MEMADR, E_NONE, 2'b00, 2'b11, 4'd0, 3'b000);
    for (int i = 0; i < 2; i++) push("lw_rstall", 0, S_MEMREAD, E_MRD, 2'b00);
    push("lw_rd", 1, S_MEMREAD, E_MRD, 2'b00);
    push("lw_wb", 1, S_MEMWB, E_RW, 2'b01);
    drain(0);

    set_instr(OP_BRANCH, F3_BNE, 1'b0);
    zero = 1'b0;
    push("bne_t_f", 1, S_FETCH, E_FGO, 2'b10);
    push("bne_t_d", 1, S_DECODE, E_NONE, 2'b00, 2'b10, 4'd0, 3'b010);
    push("bne_t_br", 1, S_BRANCH, E_PC, 2'b00, 2'b01, 4'd1);
    drain(0);
    zero = 1'b1;
    push("bne_n_f", 1, S_FETCH, E_FGO, 2'b10);
    push("bne_n_d", 1, S_DECODE, E_NONE, 2'b00);
    push("bne_n_br", 1, S_BRANCH, E_NONE, 2'b00);
    drain(0);
    zero = 1'b0;

    set_instr(OP_BRANCH, F3_BLT, 1'b0);
    lt = 1'b1;
    push("blt_f", 1, S_FETCH, E_FGO, 2'b10);
    push("blt_d", 1, S_DECODE, E_NONE, 2'b00);
    push("blt_br", 1, S_BRANCH, E_PC, 2'b00);
    drain(0);
    set_instr(OP_BRANCH, F3_BGEU, 1'b0);
    ltu = 1'b1;
    push("bgeu_f", 1, S_FETCH, E_FGO, 2'b10);
    push("bgeu_d", 1, S_DECODE, E_NONE, 2'b00);
    push("bgeu_br", 1, S_BRANCH, E_NONE, 2'b00);
    drain(0);
    ltu = 1'b0;

    set_instr(OP_JAL, 3'b000, 1'b0);
    push("jal_f", 1, S_FETCH, E_FGO, 2'b10);
    push("jal_d", 1, S_DECODE, E_NONE, 2'b00, 2'b10, 4'd0, 3'b011);
    push("jal_j", 1, S_JAL, E_PC, 2'b00, 2'b01, 4'd0);
    push("jal_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_JALR, 3'b000, 1'b0);
    push("jalr_f", 1, S_FETCH, E_FGO, 2'b10);
    push("jalr_d", 1, S_DECODE, E_NONE, 2'b00);
    push("jalr_j", 1, S_JALR, E_PC, 2'b10, 2'b10, 4'd0, 3'b000);
    push("jalr_l", 1, S_JALR_LINK, E_NONE, 2'b00);
    push("jalr_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_LUI, 3'b000, 1'b0);
    push("lui_f", 1, S_FETCH, E_FGO, 2'b10);
    push("lui_d", 1, S_DECODE, E_NONE, 2'b00);
    push("lui_x", 1, S_LUI, E_NONE, 2'b00, 2'b11, 4'd0, 3'b100);
    push("lui_wb", 1, S_ALUWB, E_RW, 2'b00);
    drain(0);

    set_instr(OP_STORE, 3'b010, 1'b0);
    push("sw_f", 1, S_FETCH, E_FGO, 2'b10);
    push("sw_d", 1, S_DECODE, E_NONE, 2'b00);
    push("sw_adr", 1, S_MEMADR, E_NONE, 2'b00, 2'b10, 4'd0, 3'b001);
    push("sw_stall", 0, S_MEMWRITE, E_MWR, 2'b00);
    push("sw_wr", 1, S_MEMWRITE, E_MWR, 2'b00);
    drain(0);

    set_instr(OP_BRANCH, 3'b010, 1'b0);
    push("brsv_f", 1, S_FETCH, E_FGO, 2'b10);
    push("brsv_d", 1, S_DECODE, E_NONE, 2'b00);
    push("brsv_br", 1, S_BRANCH, E_NONE, 2'b00);
    for (int i = 0; i < 3; i++) push("brsv_trap", 1, S_TRAP, E_TRAP, 2'b00);
    drain(0);
    reset_pulse("brsv");

    set_instr(7'b0000000, 3'b000, 1'b0);
    push("ill_f", 1, S_FETCH, E_FGO, 2'b10);
    push("ill_d", 1, S_DECODE, E_NONE, 2'b00);
    for (int i = 0; i < 3; i++) push("ill_trap", 1, S_TRAP, E_TRAP, 2'b00);
    drain(0);
    reset_pulse("ill");

    set_instr(OP_STORE, 3'b010, 1'b0);
    push("swr_f", 1, S_FETCH, E_FGO, 2'b10);
    push("swr_d", 1, S_DECODE, E_NONE, 2'b00);
    push("swr_adr", 1, S_MEMADR, E_NONE, 2'b00);
    push("swr_stall", 0, S_MEMWRITE, E_MWR, 2'b00);
    drain(0);
    reset_pulse("swr");
    push("swr_refetch", 1, S_FETCH, E_FGO, 2'b10);
    drain(0);

    set_instr(OP_BRANCH, F3_BLT, 1'b0);
    lt = 1'b1;
    rst1_n = 1'b1;
    push("nx_f", 0, S_FETCH, E_FGO, 2'b10);
    push("nx_d", 0, S_DECODE, E_NONE, 2'b00);
    push("nx_br", 0, S_BRANCH, E_NONE, 2'b00);
    for (int i = 0; i < 10; i++) push("nx_trap", 0, S_TRAP, E_TRAP, 2'b00);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
